// File: rtl/keyboard_encoder_pkg.sv
// Shared key-bit indices, PS/2 set-2 scancodes and per-key lookup helpers.
// The decoder and encoder both take their key map from here.
package keyboard_encoder_pkg;

  // Bit positions of each key in the held-key mask.
  localparam logic [2:0] KB_FORWARD     = 3'd0;
  localparam logic [2:0] KB_BACKWARD    = 3'd1;
  localparam logic [2:0] KB_TURN_LEFT   = 3'd2;
  localparam logic [2:0] KB_TURN_RIGHT  = 3'd3;
  localparam logic [2:0] KB_TRANS_UP    = 3'd4;
  localparam logic [2:0] KB_TRANS_DOWN  = 3'd5;
  localparam logic [2:0] KB_TRANS_LEFT  = 3'd6;
  localparam logic [2:0] KB_TRANS_RIGHT = 3'd7;

  // Set-2 make codes.
  localparam logic [7:0] SC_FORWARD     = 8'h1D;
  localparam logic [7:0] SC_BACKWARD    = 8'h1B;
  localparam logic [7:0] SC_TURN_LEFT   = 8'h1C;
  localparam logic [7:0] SC_TURN_RIGHT  = 8'h23;
  localparam logic [7:0] SC_TRANS_UP    = 8'h75;
  localparam logic [7:0] SC_TRANS_DOWN  = 8'h72;
  localparam logic [7:0] SC_TRANS_LEFT  = 8'h6B;
  localparam logic [7:0] SC_TRANS_RIGHT = 8'h74;

  // Extended prefix and break prefix.
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Scancode for a key index.
  function automatic logic [7:0] kb_scancode(input logic [2:0] idx);
    logic [7:0] code;
    code = 8'h00;
    case (idx)
      KB_FORWARD:     code = SC_FORWARD;
      KB_BACKWARD:    code = SC_BACKWARD;
      KB_TURN_LEFT:   code = SC_TURN_LEFT;
      KB_TURN_RIGHT:  code = SC_TURN_RIGHT;
      KB_TRANS_UP:    code = SC_TRANS_UP;
      KB_TRANS_DOWN:  code = SC_TRANS_DOWN;
      KB_TRANS_LEFT:  code = SC_TRANS_LEFT;
      KB_TRANS_RIGHT: code = SC_TRANS_RIGHT;
      default:        code = 8'h00;
    endcase
    return code;
  endfunction

  // Arrow keys need the E0 prefix; WASD keys do not.
  function automatic logic kb_is_extended(input logic [2:0] idx);
    logic ext;
    ext = 1'b0;
    case (idx)
      KB_TRANS_UP, KB_TRANS_DOWN, KB_TRANS_LEFT, KB_TRANS_RIGHT: ext = 1'b1;
      default: ext = 1'b0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/kb_change_picker.sv
// Combinational lowest-set-bit priority encoder over the pending-change mask.
module kb_change_picker (
  input  logic [7:0] pending,
  output logic [2:0] index,
  output logic       found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) begin
        index = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keyboard_encoder.sv
// Turns a held-key bitmask into a PS/2 set-2 byte stream (make, break, E0)
// with a valid/ready handshake. One key event is in flight at a time.
module keyboard_encoder
  import keyboard_encoder_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] kb_in,
  output logic [7:0] code_out,
  output logic       code_valid_out,
  input  logic       code_ready_in,
  output logic       busy_out,
  output logic [7:0] sent_state_out
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StPrefix,
    StBreak,
    StCode,
    StGap
  } state_e;

  state_e            state;
  logic [7:0]        code_q;
  logic              valid_q;
  logic              busy_q;
  logic [7:0]        sent_q;
  logic [2:0]        idx_q;
  logic              make_q;
  logic [GapW-1:0]   gap_cnt;

  logic [7:0]        pending;
  logic [2:0]        pick_idx;
  logic              pick_found;
  logic              xfer;

  // Keys whose requested state differs from what the consumer last saw.
  assign pending = kb_in ^ sent_q;
  assign xfer    = valid_q & code_ready_in;

  kb_change_picker u_picker (
    .pending (pending),
    .index   (pick_idx),
    .found   (pick_found)
  );

  // Event sequencer: scan in IDLE, then walk E0 / F0 / code bytes on each transfer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= StIdle;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= 8'h00;
      idx_q   <= 3'd0;
      make_q  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pick_found) begin
            idx_q   <= pick_idx;
            make_q  <= kb_in[pick_idx];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            if (kb_is_extended(pick_idx)) begin
              code_q <= SC_E0;
              state  <= StPrefix;
            end else if (!kb_in[pick_idx]) begin
              code_q <= SC_F0;
              state  <= StBreak;
            end else begin
              code_q <= kb_scancode(pick_idx);
              state  <= StCode;
            end
          end
        end

        StPrefix: begin
          if (xfer) begin
            if (!make_q) begin
              code_q <= SC_F0;
              state  <= StBreak;
            end else begin
              code_q <= kb_scancode(idx_q);
              state  <= StCode;
            end
          end
        end

        StBreak: begin
          if (xfer) begin
            code_q <= kb_scancode(idx_q);
            state  <= StCode;
          end
        end

        StCode: begin
          if (xfer) begin
            // Only a completed sequence commits the key state.
            sent_q[idx_q] <= make_q;
            valid_q       <= 1'b0;
            if (GAP_CYCLES == 0) begin
              busy_q <= 1'b0;
              state  <= StIdle;
            end else begin
              gap_cnt <= '0;
              state   <= StGap;
            end
          end
        end

        StGap: begin
          if (gap_cnt == GapW'(GAP_CYCLES - 1)) begin
            busy_q <= 1'b0;
            state  <= StIdle;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

  assign code_out       = code_q;
  assign code_valid_out = valid_q;
  assign busy_out       = busy_q;
  assign sent_state_out = sent_q;

endmodule
